// File: rtl/decode_pkg.sv
// Shared decode definitions: ALU op codes (also used by the execute-stage ALU),
// RV32I opcode/funct constants and the decoded-control record.
package decode_pkg;

    typedef enum logic [4:0] {
        OP_NOP,  OP_ADD,  OP_SUB,  OP_AND,  OP_OR,   OP_XOR,  OP_SLT,  OP_SLTU,
        OP_SRA,  OP_SRL,  OP_SLL,  OP_ADDI, OP_ANDI, OP_ORI,  OP_XORI, OP_SLTI,
        OP_SLTIU, OP_SRAI, OP_SRLI, OP_SLLI, OP_LUI, OP_LW,   OP_SW,   OP_BEQ,
        OP_BNE,  OP_BLT,  OP_BGE,  OP_BLTU, OP_BGEU, OP_AUIPC, OP_JAL, OP_JALR
    } alu_op_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
    } imm_fmt_t;

    typedef struct packed {
        alu_op_t  op;
        logic     illegal;
        logic     src_imm;
        logic     reg_we;
        logic     mem_re;
        logic     mem_we;
        logic     use_rs2;
        imm_fmt_t fmt;
    } dec_t;

endpackage

// File: rtl/decode_if.sv
// Decode-stage bus: fetch-side inputs, branch feedback from the ALU and the
// registered E-stage outputs. master = surrounding pipeline, slave = decode stage.
interface decode_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  instr_d;
    logic [XLEN-1:0]  pc_d;
    logic             valid_d;
    logic             stall_in;
    logic [1:0]       pc_branch_en_sel;
    logic             stall_fd;
    logic [4:0]       alu_op_e;
    logic             alu_en_e;
    logic             alu_src_imm_e;
    logic [XLEN-1:0]  imm_e;
    logic [XLEN-1:0]  pc_e;
    logic [4:0]       rs1_e;
    logic [4:0]       rs2_e;
    logic [4:0]       rd_e;
    logic             reg_we_e;
    logic             mem_re_e;
    logic             mem_we_e;
    logic             illegal_e;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output instr_d, pc_d, valid_d, stall_in, pc_branch_en_sel,
        input  stall_fd, alu_op_e, alu_en_e, alu_src_imm_e, imm_e, pc_e,
               rs1_e, rs2_e, rd_e, reg_we_e, mem_re_e, mem_we_e, illegal_e, illegal_cnt
    );

    modport slave (
        input  instr_d, pc_d, valid_d, stall_in, pc_branch_en_sel,
        output stall_fd, alu_op_e, alu_en_e, alu_src_imm_e, imm_e, pc_e,
               rs1_e, rs2_e, rd_e, reg_we_e, mem_re_e, mem_we_e, illegal_e, illegal_cnt
    );
endinterface

// File: rtl/decode_imm_gen.sv
// Combinational immediate extraction; the format is chosen by the decoder.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm
);
    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_SH:  imm32 = {27'd0, instr[24:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'd0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed source, so widening to XLEN sign-extends.
    assign imm = XLEN'(imm32);
endmodule

// File: rtl/decode_stage.sv
// RV32I decode with D->E pipeline register, load-use bubble insertion,
// branch squash and a saturating illegal-instruction counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic     clk,
    input logic     rst,
    decode_if.slave bus
);
    typedef struct packed {
        alu_op_t         op;
        logic            en;
        logic            src_imm;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_we;
        logic            mem_re;
        logic            mem_we;
        logic            illegal;
    } e_reg_t;

    logic [31:0]      ins;
    logic [6:0]       opc, f7;
    logic [2:0]       f3;
    logic [4:0]       rs1_d, rs2_d, rd_d;
    dec_t             dec;
    logic [XLEN-1:0]  imm_d;
    e_reg_t           e_q, e_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             hazard, squash, inc_cnt;

    assign ins   = bus.instr_d[31:0];
    assign opc   = ins[6:0];
    assign rd_d  = ins[11:7];
    assign f3    = ins[14:12];
    assign rs1_d = ins[19:15];
    assign rs2_d = ins[24:20];
    assign f7    = ins[31:25];

    always_comb begin
        dec.op      = OP_NOP;
        dec.illegal = 1'b0;
        dec.src_imm = 1'b0;
        dec.reg_we  = 1'b0;
        dec.mem_re  = 1'b0;
        dec.mem_we  = 1'b0;
        dec.use_rs2 = 1'b0;
        dec.fmt     = FMT_NONE;
        case (opc)
            OPC_OP: begin
                dec.reg_we  = 1'b1;
                dec.use_rs2 = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD_SUB: dec.op = OP_ADD;
                        F3_SLL:     dec.op = OP_SLL;
                        F3_SLT:     dec.op = OP_SLT;
                        F3_SLTU:    dec.op = OP_SLTU;
                        F3_XOR:     dec.op = OP_XOR;
                        F3_SR:      dec.op = OP_SRL;
                        F3_OR:      dec.op = OP_OR;
                        default:    dec.op = OP_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == F3_ADD_SUB)  dec.op = OP_SUB;
                    else if (f3 == F3_SR)  dec.op = OP_SRA;
                end
            end
            OPC_OP_IMM: begin
                dec.reg_we  = 1'b1;
                dec.src_imm = 1'b1;
                dec.fmt     = FMT_I;
                case (f3)
                    F3_ADD_SUB: dec.op = OP_ADDI;
                    F3_SLT:     dec.op = OP_SLTI;
                    F3_SLTU:    dec.op = OP_SLTIU;
                    F3_XOR:     dec.op = OP_XORI;
                    F3_OR:      dec.op = OP_ORI;
                    F3_AND:     dec.op = OP_ANDI;
                    F3_SLL: begin
                        dec.fmt = FMT_SH;
                        if (f7 == F7_BASE) dec.op = OP_SLLI;
                    end
                    default: begin
                        dec.fmt = FMT_SH;
                        if (f7 == F7_BASE)     dec.op = OP_SRLI;
                        else if (f7 == F7_ALT) dec.op = OP_SRAI;
                    end
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.op      = (opc == OPC_LUI) ? OP_LUI : OP_AUIPC;
                dec.reg_we  = 1'b1;
                dec.src_imm = 1'b1;
                dec.fmt     = FMT_U;
            end
            OPC_JAL: begin
                dec.op      = OP_JAL;
                dec.reg_we  = 1'b1;
                dec.src_imm = 1'b1;
                dec.fmt     = FMT_J;
            end
            OPC_JALR: begin
                if (f3 == F3_JALR) dec.op = OP_JALR;
                dec.reg_we  = 1'b1;
                dec.src_imm = 1'b1;
                dec.fmt     = FMT_I;
            end
            OPC_LOAD: begin
                if (f3 == F3_WORD) dec.op = OP_LW;
                dec.reg_we  = 1'b1;
                dec.mem_re  = 1'b1;
                dec.src_imm = 1'b1;
                dec.fmt     = FMT_I;
            end
            OPC_STORE: begin
                if (f3 == F3_WORD) dec.op = OP_SW;
                dec.mem_we  = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.src_imm = 1'b1;
                dec.fmt     = FMT_S;
            end
            OPC_BRANCH: begin
                dec.use_rs2 = 1'b1;
                dec.fmt     = FMT_B;
                case (f3)
                    F3_BEQ:  dec.op = OP_BEQ;
                    F3_BNE:  dec.op = OP_BNE;
                    F3_BLT:  dec.op = OP_BLT;
                    F3_BGE:  dec.op = OP_BGE;
                    F3_BLTU: dec.op = OP_BLTU;
                    F3_BGEU: dec.op = OP_BGEU;
                    default: dec.op = OP_NOP;
                endcase
            end
            default: ;
        endcase

        // Any encoding that never reached a real op is illegal and carries no side effects.
        if (dec.op == OP_NOP) begin
            dec.illegal = 1'b1;
            dec.src_imm = 1'b0;
            dec.reg_we  = 1'b0;
            dec.mem_re  = 1'b0;
            dec.mem_we  = 1'b0;
            dec.use_rs2 = 1'b0;
            dec.fmt     = FMT_NONE;
        end else if (rd_d == 5'd0) begin
            dec.reg_we  = 1'b0;
        end
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (ins[31:7]),
        .fmt   (dec.fmt),
        .imm   (imm_d)
    );

    assign squash = (bus.pc_branch_en_sel == 2'b10);
    assign hazard = bus.valid_d && e_q.en && e_q.mem_re && (e_q.rd != 5'd0) &&
                    ((e_q.rd == rs1_d) || (dec.use_rs2 && (e_q.rd == rs2_d)));
    assign bus.stall_fd = hazard && !squash;

    always_comb begin
        e_nxt   = '0;
        inc_cnt = 1'b0;
        if (!squash && bus.stall_in) begin
            e_nxt = e_q;
        end else if (!squash && !hazard && bus.valid_d) begin
            e_nxt.op      = dec.op;
            e_nxt.en      = 1'b1;
            e_nxt.src_imm = dec.src_imm;
            e_nxt.imm     = imm_d;
            e_nxt.pc      = bus.pc_d;
            e_nxt.rs1     = rs1_d;
            e_nxt.rs2     = rs2_d;
            e_nxt.rd      = rd_d;
            e_nxt.reg_we  = dec.reg_we;
            e_nxt.mem_re  = dec.mem_re;
            e_nxt.mem_we  = dec.mem_we;
            e_nxt.illegal = dec.illegal;
            inc_cnt       = dec.illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q <= e_nxt;
            if (inc_cnt && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.alu_op_e      = e_q.op;
    assign bus.alu_en_e      = e_q.en;
    assign bus.alu_src_imm_e = e_q.src_imm;
    assign bus.imm_e         = e_q.imm;
    assign bus.pc_e          = e_q.pc;
    assign bus.rs1_e         = e_q.rs1;
    assign bus.rs2_e         = e_q.rs2;
    assign bus.rd_e          = e_q.rd;
    assign bus.reg_we_e      = e_q.reg_we;
    assign bus.mem_re_e      = e_q.mem_re;
    assign bus.mem_we_e      = e_q.mem_we;
    assign bus.illegal_e     = e_q.illegal;
    assign bus.illegal_cnt   = cnt_q;
endmodule
